fxp_conv_arbiter: RTL and testbench

Shares one `fp_to_fixed` / `fixed_to_fp` converter pair between `NUM_REQ` requesters. Requests are arbitrated round-robin and routed through the selected converter. The result is registered into a single response slot with valid/ready handshake. It sits between client blocks needing float↔fixed (sign, 1-bit integer, 19-bit fraction) conversion and the shared conversion datapath, which it instantiates internally.

---
 rtl/fxp_conv_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fxp_conv_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_conv_arbiter.sv
// Round-robin arbiter sharing one float<->fixed (sign-magnitude s.1.19) converter pair.
// Define FXP_CONV_ARB_STATS_EN to add the conv_count_o handshake counter.
module fxp_conv_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_op_i,
    input  logic [NUM_REQ*32-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic                  rsp_op_o,
    output logic [31:0]           rsp_data_o
`ifdef FXP_CONV_ARB_STATS_EN
    ,
    output logic [15:0]           conv_count_o
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_op_q, rsp_op_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic            can_accept;
    logic            grant;
    logic [31:0]     sel_data;
    logic            sel_op;
    logic [31:0]     f2x_in, x2f_in;
    logic [31:0]     conv_out;

    // Truncates toward zero; |x| >= 2.0 (incl. inf/NaN) saturates, denormals flush to zero.
    function automatic logic [31:0] fp_to_fixed(input logic [31:0] f);
        logic [7:0]  exp;
        logic [7:0]  sh;
        logic [23:0] sig;
        logic [23:0] shifted;
        logic [19:0] mag;
        exp     = f[30:23];
        sig     = {1'b1, f[22:0]};
        sh      = 8'd131 - exp;
        shifted = sig >> sh;
        mag     = '0;
        if (exp == 8'd0) begin
            mag = '0;
        end else if (exp >= 8'd128) begin
            mag = '1;
        end else if (sh < 8'd24) begin
            mag = shifted[19:0];
        end
        return {11'd0, f[31] & (|mag), mag};
    endfunction

    // Exact: 20 magnitude bits always fit the 24-bit significand. Zero maps to +0.
    function automatic logic [31:0] fixed_to_fp(input logic [31:0] x);
        logic [19:0] mag;
        logic [4:0]  msb;
        logic [23:0] norm;
        logic [7:0]  exp;
        logic [31:0] res;
        mag = x[19:0];
        msb = '0;
        for (int i = 0; i < 20; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        norm = {4'd0, mag} << (5'd23 - msb);
        exp  = 8'd108 + {3'd0, msb};
        res  = {x[20], exp, norm[22:0]};
        if (mag == '0) res = '0;
        return res;
    endfunction

    // Round-robin search starting just above the last winner.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign can_accept  = (state_q == StEmpty) || rsp_ready_i;
    assign grant       = win_found && can_accept && rst_n;
    assign req_ready_o = grant ? (NUM_REQ'(1) << win_idx) : '0;

    assign sel_data = req_data_i[{win_idx, 5'd0} +: 32];
    assign sel_op   = req_op_i[win_idx];
    assign f2x_in   = (grant && !sel_op) ? sel_data : '0;
    assign x2f_in   = (grant && sel_op) ? sel_data : '0;
    assign conv_out = sel_op ? fixed_to_fp(x2f_in) : fp_to_fixed(f2x_in);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_op_d     = rsp_op_q;
        rsp_data_d   = rsp_data_q;
        if (grant) begin
            last_grant_d = win_idx;
            rsp_id_d     = win_idx;
            rsp_op_d     = sel_op;
            rsp_data_d   = conv_out;
        end
        unique case (state_q)
            StEmpty: if (grant) state_d = StFull;
            StFull:  if (rsp_ready_i && !grant) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rsp_op_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_op_q     <= rsp_op_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid_o = (state_q == StFull);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_data_o  = rsp_data_q;

`ifdef FXP_CONV_ARB_STATS_EN
    logic [15:0] conv_count_q, conv_count_d;

    assign conv_count_d = (rsp_valid_o && rsp_ready_i) ? conv_count_q + 16'd1 : conv_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count_q <= '0;
        end else begin
            conv_count_q <= conv_count_d;
        end
    end

    assign conv_count_o = conv_count_q;
`endif

endmodule

// File: tb/tb_fxp_conv_arbiter.sv
// Self-checking bench for fxp_conv_arbiter: directed scenarios plus randomized traffic
// against a real-arithmetic conversion model and a round-robin transaction model.
module tb_fxp_conv_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [N-1:0]   ready;
    logic [N-1:0]   ops;
    logic [N*32-1:0] data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           rsp_op;
    logic [31:0]    rsp_data;
`ifdef FXP_CONV_ARB_STATS_EN
    logic [15:0]    conv_count;
`endif

    fxp_conv_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_op_i    (ops),
        .req_data_i  (data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_op_o    (rsp_op),
        .rsp_data_o  (rsp_data)
`ifdef FXP_CONV_ARB_STATS_EN
        ,
        .conv_count_o(conv_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model state
    logic        m_valid;
    int          m_id;
    logic        m_op;
    logic [31:0] m_data;
    int          m_last;
    int          m_cnt;
    int          m_win;
    logic        m_acc;
    logic [N-1:0] exp_ready;

    function automatic logic [31:0] m_f2x(input logic [31:0] f);
        int  e;
        int  mant;
        int  mag;
        real v;
        e    = int'(f[30:23]);
        mant = int'(f[22:0]);
        if (e == 0) mag = 0;
        else if (e >= 128) mag = 'hFFFFF;
        else begin
            v = 1.0 + mant / 8388608.0;
            for (int k = e; k < 127; k++) v = v / 2.0;
            mag = $rtoi(v * 524288.0);
        end
        return {11'd0, (f[31] && mag != 0), 20'(mag)};
    endfunction

    function automatic logic [31:0] m_x2f(input logic [31:0] x);
        int          mi;
        int          de;
        real         v;
        logic [63:0] b;
        mi = int'(x[19:0]);
        if (mi == 0) return 32'h0;
        v  = mi / 524288.0;
        b  = $realtobits(v);
        de = int'(b[62:52]) - 1023 + 127;
        return {x[20], 8'(de), b[51:29]};
    endfunction

    function automatic logic [31:0] rand_word(input logic op);
        int e;
        int r;
        if (op) return $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) e = 0;
        else if (r == 1) e = 255;
        else if (r == 2) e = $urandom_range(128, 140);
        else e = $urandom_range(100, 127);
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic m_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_op    = 1'b0;
        m_data  = 32'h0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    task automatic predict();
        m_win = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (m_win < 0 && valid[c]) m_win = c;
        end
        m_acc     = rst_n && (!m_valid || rsp_ready) && (m_win >= 0);
        exp_ready = m_acc ? (N'(1) << m_win) : '0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] o,
                         input logic [N*32-1:0] d, input logic rr);
        @(negedge clk);
        valid     = v;
        ops       = o;
        data      = d;
        rsp_ready = rr;
        #1;
        predict();
    endtask

    task automatic advance();
        if (m_valid && rsp_ready) m_cnt++;
        if (m_acc) begin
            m_valid = 1'b1;
            m_id    = m_win;
            m_op    = ops[m_win];
            m_data  = ops[m_win] ? m_x2f(data[m_win*32 +: 32]) : m_f2x(data[m_win*32 +: 32]);
            m_last  = m_win;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '1;
        ops = '0;
        data = '0;
        rsp_ready = 1'b1;
        #13;
        checks++;
        if (ready !== '0) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected 0000", ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_op, rsp_data} !== 36'h0) begin
            failures++;
            $display("FAIL reset_rsp: got v=%b id=%0d op=%b d=%h expected all zero",
                     rsp_valid, rsp_id, rsp_op, rsp_data);
        end
        @(negedge clk);
        valid = '0;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_single_f2x();
        drive(4'b0001, 4'b0000, {96'h0, 32'h3FC00000}, 1'b1);
        checks++;
        if (ready !== 4'b0001) begin
            failures++;
            $display("FAIL f2x_ready: got %b expected 0001", ready);
        end
        advance();
        checks++;
        if ({rsp_valid, rsp_id, rsp_op, rsp_data} !== {1'b1, 2'd0, 1'b0, 32'h000C0000}) begin
            failures++;
            $display("FAIL f2x_rsp: got v=%b id=%0d op=%b d=%h expected v=1 id=0 op=0 d=000c0000",
                     rsp_valid, rsp_id, rsp_op, rsp_data);
        end
        drive('0, '0, '0, 1'b1);
        advance();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL f2x_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_single_x2f();
        drive(4'b0100, 4'b0100, {32'h0, 32'hFFF20000, 64'h0}, 1'b1);
        checks++;
        if (ready !== 4'b0100) begin
            failures++;
            $display("FAIL x2f_ready: got %b expected 0100", ready);
        end
        advance();
        checks++;
        if ({rsp_valid, rsp_id, rsp_op, rsp_data} !== {1'b1, 2'd2, 1'b1, 32'hBE800000}) begin
            failures++;
            $display("FAIL x2f_rsp: got v=%b id=%0d op=%b d=%h expected v=1 id=2 op=1 d=be800000",
                     rsp_valid, rsp_id, rsp_op, rsp_data);
        end
        drive('0, '0, '0, 1'b1);
        advance();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0]    o;
        logic [N*32-1:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            o = N'($urandom);
            for (int j = 0; j < N; j++) d[j*32 +: 32] = rand_word(o[j]);
            drive('1, o, d, 1'b1);
            checks++;
            if (ready !== (N'(1) << order[i])) begin
                failures++;
                $display("FAIL rr_ready[%0d]: got %b expected one-hot %0d", i, ready, order[i]);
            end
            advance();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(order[i]), m_data}) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                         i, rsp_valid, rsp_id, rsp_data, order[i], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0]    o;
        logic [N*32-1:0] d;
        int              held_id;
        logic [31:0]     held_data;
        o = N'($urandom);
        for (int j = 0; j < N; j++) d[j*32 +: 32] = rand_word(o[j]);
        drive('1, o, d, 1'b1);
        advance();
        held_id   = m_id;
        held_data = m_data;
        for (int i = 0; i < 5; i++) begin
            drive('1, o, d, 1'b0);
            checks++;
            if (ready !== '0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %b expected 0000", i, ready);
            end
            advance();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(held_id), held_data}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                         i, rsp_valid, rsp_id, rsp_data, held_id, held_data);
            end
        end
        drive('1, o, d, 1'b1);
        checks++;
        if (ready !== (N'(1) << ((held_id + 1) % N))) begin
            failures++;
            $display("FAIL bp_release_ready: got %b expected one-hot %0d", ready, (held_id + 1) % N);
        end
        advance();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'((held_id + 1) % N), m_data}) begin
            failures++;
            $display("FAIL bp_release_rsp: got id=%0d d=%h expected id=%0d d=%h",
                     rsp_id, rsp_data, (held_id + 1) % N, m_data);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    v;
        logic [N-1:0]    o;
        logic [N*32-1:0] d;
        for (int i = 0; i < 400; i++) begin
            v = N'($urandom);
            o = N'($urandom);
            for (int j = 0; j < N; j++) d[j*32 +: 32] = rand_word(o[j]);
            drive(v, o, d, $urandom_range(0, 9) < 7);
            checks++;
            if (ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, ready, exp_ready);
            end
            advance();
            checks++;
            if ({rsp_valid, rsp_id, rsp_op, rsp_data} !== {m_valid, 2'(m_id), m_op, m_data}) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got v=%b id=%0d op=%b d=%h expected v=%b id=%0d op=%b d=%h",
                         i, rsp_valid, rsp_id, rsp_op, rsp_data, m_valid, m_id, m_op, m_data);
            end
`ifdef FXP_CONV_ARB_STATS_EN
            checks++;
            if (conv_count !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL rand_count[%0d]: got %0d expected %0d", i, conv_count, 16'(m_cnt));
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b0010, 4'b0000, {64'h0, 32'h3F800000, 32'h0}, 1'b0);
        advance();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_rsp_valid: got %b expected 0", rsp_valid);
        end
        checks++;
        if (ready !== '0) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 0000", ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        drive(4'b0011, 4'b0000, {64'h0, 32'h40000000, 32'h3F000000}, 1'b1);
        checks++;
        if (ready !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_prio: got %b expected 0001", ready);
        end
        advance();
        checks++;
        if ({rsp_id, rsp_data} !== {2'd0, 32'h00040000}) begin
            failures++;
            $display("FAIL midreset_rsp: got id=%0d d=%h expected id=0 d=00040000", rsp_id, rsp_data);
        end
    endtask

`ifdef FXP_CONV_ARB_STATS_EN
    // First grant cycle fills the slot; each later cycle is a handshake, so 65538 grants
    // yield 65537 handshakes and the counter wraps to 1.
    task automatic test_stats_wrap();
        do_reset();
        for (int i = 0; i < 65538; i++) begin
            drive(4'b0001, 4'b0000, {96'h0, 32'h3F800000}, 1'b1);
            advance();
        end
        checks++;
        if (conv_count !== 16'd1) begin
            failures++;
            $display("FAIL stats_wrap: got %0d expected 1", conv_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_f2x();
        test_single_x2f();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef FXP_CONV_ARB_STATS_EN
        test_stats_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
